// File: rtl/div_issue_ctrl_if.sv
// Signal bundle between the control FSM / divider and the divide issue controller.
// slave = the issue controller, master = whatever drives its inputs.
interface div_issue_ctrl_if #(parameter int DATA_WIDTH = 6);
    logic                  div_req;
    logic                  div_signed;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic                  mflo_req;
    logic [DATA_WIDTH-1:0] lo_data;
    logic                  stall;
    logic                  busy;
    logic                  div_by_zero;
    logic                  div_timeout;
    logic                  div_start;
    logic [DATA_WIDTH-1:0] div_op1;
    logic [DATA_WIDTH-1:0] div_op2;
    logic [DATA_WIDTH-1:0] div_result;
    logic                  div_done;

    modport slave (
        input  div_req, div_signed, rs_data, rt_data, mflo_req, div_result, div_done,
        output lo_data, stall, busy, div_by_zero, div_timeout, div_start, div_op1, div_op2
    );

    modport master (
        output div_req, div_signed, rs_data, rt_data, mflo_req, div_result, div_done,
        input  lo_data, stall, busy, div_by_zero, div_timeout, div_start, div_op1, div_op2
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/retire control for the iterative unsigned divider: magnitude conversion,
// start pulse, completion wait with timeout, sign fix-up into LO.
module div_issue_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int TIMEOUT    = 2*DATA_WIDTH+4
) (
    input  logic           CLK,
    input  logic           RST,
    div_issue_ctrl_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIX} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   op1_q, op1_d;
    logic [W-1:0]   op2_q, op2_d;
    logic [W-1:0]   quo_q, quo_d;
    logic           neg_q, neg_d;
    logic           dbz_q, dbz_d;
    logic           to_q, to_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           start;

    // -2^(W-1) maps to 2^(W-1), which still fits as an unsigned W-bit value
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
        return (sgn && x[W-1]) ? (~x + W'(1)) : x;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            lo_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            quo_q   <= '0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            quo_q   <= quo_d;
            neg_q   <= neg_d;
            dbz_q   <= dbz_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        quo_d   = quo_q;
        neg_d   = neg_q;
        dbz_d   = dbz_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.div_req) begin
                    to_d = 1'b0;
                    if (bus.rt_data == '0) begin
                        // Zero divisor is resolved here; the divider never sees it
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        dbz_d   = 1'b0;
                        op1_d   = mag(bus.rs_data, bus.div_signed);
                        op2_d   = mag(bus.rt_data, bus.div_signed);
                        neg_d   = bus.div_signed & (bus.rs_data[W-1] ^ bus.rt_data[W-1]);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                start   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // done has priority over an expiring counter
                if (bus.div_done) begin
                    quo_d   = bus.div_result;
                    state_d = FIX;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    lo_d    = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                lo_d    = neg_q ? (~quo_q + W'(1)) : quo_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.stall       = bus.busy & (bus.mflo_req | bus.div_req);
    assign bus.div_start   = start;
    assign bus.lo_data     = lo_q;
    assign bus.div_op1     = op1_q;
    assign bus.div_op2     = op2_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.div_timeout = to_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl; the bench plays both the control FSM
// and the divider, and predicts LO from signed/unsigned integer division.
module tb_div_issue_ctrl;
    localparam int W  = 6;
    localparam int TO = 2*W+4;

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    div_issue_ctrl_if #(.DATA_WIDTH(W)) bus();

    div_issue_ctrl #(.DATA_WIDTH(W), .TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_int(input logic sgn, input logic [W-1:0] x);
        int v;
        if (sgn) v = $signed(x);
        else     v = int'(x);
        return v;
    endfunction

    function automatic logic [W-1:0] exp_mag(input logic sgn, input logic [W-1:0] x);
        int v;
        v = to_int(sgn, x);
        if (v < 0) v = -v;
        return W'(v);
    endfunction

    function automatic logic [W-1:0] exp_quot(input logic sgn, input logic [W-1:0] rs, input logic [W-1:0] rt);
        if (rt == '0) return '1;
        return W'(to_int(sgn, rs) / to_int(sgn, rt));
    endfunction

    task automatic quiet();
        bus.div_req    = 1'b0;
        bus.div_signed = 1'b0;
        bus.rs_data    = '0;
        bus.rt_data    = '0;
        bus.mflo_req   = 1'b0;
        bus.div_result = '0;
        bus.div_done   = 1'b0;
    endtask

    // Presents a request and leaves the bench at the cycle after acceptance
    task automatic present(input logic sgn, input logic [W-1:0] rs, input logic [W-1:0] rt);
        @(negedge CLK);
        bus.div_req    = 1'b1;
        bus.div_signed = sgn;
        bus.rs_data    = rs;
        bus.rt_data    = rt;
        bus.mflo_req   = 1'b0;
        #1;
        chk("idle_stall", bus.stall, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        @(negedge CLK);
        bus.div_req = 1'b0;
        bus.rs_data = W'($urandom);
        bus.rt_data = W'($urandom);
        #1;
    endtask

    task automatic run_op(input logic sgn, input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input int delay, input bit level, input bit noise);
        logic [W-1:0] eq, m1, m2;
        bit m, r;
        eq = exp_quot(sgn, rs, rt);
        m1 = exp_mag(sgn, rs);
        m2 = exp_mag(sgn, rt);
        present(sgn, rs, rt);
        if (rt == '0) begin
            chk("dbz_lo", bus.lo_data, eq);
            chk("dbz_flag", bus.div_by_zero, 1'b1);
            chk("dbz_to", bus.div_timeout, 1'b0);
            chk("dbz_busy", bus.busy, 1'b0);
            chk("dbz_start", bus.div_start, 1'b0);
            return;
        end
        chk("iss_start", bus.div_start, 1'b1);
        chk("iss_op1", bus.div_op1, m1);
        chk("iss_op2", bus.div_op2, m2);
        chk("iss_busy", bus.busy, 1'b1);
        chk("iss_flags", {bus.div_by_zero, bus.div_timeout}, 2'b00);
        for (int c = 0; c <= delay; c++) begin
            @(negedge CLK);
            m = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            r = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.mflo_req   = m;
            bus.div_req    = r;
            bus.div_signed = 1'($urandom);
            bus.rs_data    = W'($urandom);
            bus.rt_data    = W'($urandom);
            if (c == delay) begin
                bus.div_done   = 1'b1;
                bus.div_result = m1 / m2;
            end
            #1;
            chk("wait_start", bus.div_start, 1'b0);
            chk("wait_busy", bus.busy, 1'b1);
            chk("wait_stall", bus.stall, m | r);
            chk("wait_ops", {bus.div_op1, bus.div_op2}, {m1, m2});
        end
        @(negedge CLK);
        if (!level) bus.div_done = 1'b0;
        bus.mflo_req = 1'b1;
        bus.div_req  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        chk("fix_busy", bus.busy, 1'b1);
        chk("fix_stall", bus.stall, 1'b1);
        @(negedge CLK);
        bus.div_req  = 1'b0;
        bus.mflo_req = 1'b1;
        #1;
        chk("done_lo", bus.lo_data, eq);
        chk("done_busy", bus.busy, 1'b0);
        chk("done_stall", bus.stall, 1'b0);
        chk("done_flags", {bus.div_by_zero, bus.div_timeout}, 2'b00);
        bus.mflo_req = 1'b0;
        if (level) begin
            @(negedge CLK);
            bus.div_done = 1'b0;
            #1;
            chk("lvl_busy", bus.busy, 1'b0);
            chk("lvl_lo", bus.lo_data, eq);
        end
    endtask

    task automatic run_timeout(input logic sgn, input logic [W-1:0] rs, input logic [W-1:0] rt);
        present(sgn, rs, rt);
        chk("to_start", bus.div_start, 1'b1);
        for (int c = 1; c <= TO; c++) begin
            @(negedge CLK);
            #1;
            if (bus.busy !== 1'b1) chk("to_wait_busy", bus.busy, 1'b1);
        end
        @(negedge CLK);
        #1;
        chk("to_busy", bus.busy, 1'b0);
        chk("to_flag", bus.div_timeout, 1'b1);
        chk("to_lo", bus.lo_data, '0);
        chk("to_dbz", bus.div_by_zero, 1'b0);
    endtask

    task automatic run_reset_mid();
        present(1'b0, W'(21), W'(7));
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk("rst_pre_busy", bus.busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_lo", bus.lo_data, '0);
        chk("rst_start", bus.div_start, 1'b0);
        bus.div_done   = 1'b1;
        bus.div_result = W'(3);
        @(negedge CLK);
        bus.div_done = 1'b0;
        #1;
        chk("late_done_busy", bus.busy, 1'b0);
        chk("late_done_lo", bus.lo_data, '0);
    endtask

    initial begin
        logic [W-1:0] rs, rt;
        quiet();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        bus.mflo_req = 1'b1;
        #1;
        chk("rst_lo0", bus.lo_data, '0);
        chk("rst_busy0", bus.busy, 1'b0);
        chk("rst_stall0", bus.stall, 1'b0);
        chk("rst_start0", bus.div_start, 1'b0);
        chk("rst_ops0", {bus.div_op1, bus.div_op2}, '0);
        chk("rst_flags0", {bus.div_by_zero, bus.div_timeout}, 2'b00);
        bus.mflo_req = 1'b0;
        RST = 1'b0;

        run_op(1'b0, W'(21), W'(7), 3, 1'b0, 1'b0);
        run_op(1'b1, 6'b101011, W'(7), 2, 1'b0, 1'b0);
        run_op(1'b1, W'(21), 6'b111001, 0, 1'b1, 1'b0);
        run_op(1'b0, W'(13), W'(0), 0, 1'b0, 1'b0);
        run_op(1'b0, W'(20), W'(4), 1, 1'b0, 1'b0);
        run_op(1'b1, 6'b100000, 6'b111111, 4, 1'b0, 1'b0);
        run_op(1'b0, W'(50), W'(6), 5, 1'b0, 1'b1);
        run_timeout(1'b0, W'(21), W'(7));
        run_op(1'b1, W'(9), W'(2), TO-1, 1'b0, 1'b1);
        run_reset_mid();

        for (int i = 0; i < 60; i++) begin
            rs = W'($urandom);
            rt = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom);
            run_op(1'($urandom), rs, rt, $urandom_range(0, TO-1),
                   1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
